// File: rtl/io_input_ctrl.sv
// Switch-port synchroniser/debouncer with CPU read path; optional masked IRQ under IO_INPUT_IRQ_EN.
// Reads return one cycle after rd_en; no backpressure, every strobe is served.
module io_input_ctrl #(
  parameter int NPORTS          = 2,
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      io_clk,
  input  logic                      resetn,
  input  logic [NPORTS*WIDTH-1:0]   in_port,
  input  logic [31:0]               addr,
  input  logic                      rd_en,
  input  logic                      wr_en,
  input  logic [31:0]               wr_data,
  output logic [31:0]               io_read_data,
  output logic                      rd_valid,
  output logic                      irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES);
  localparam logic [5:0]    IDX_STATUS = 6'd8;
  localparam logic [5:0]    IDX_MASK   = 6'd9;

  typedef logic [NPORTS-1:0][WIDTH-1:0] port_vec_t;
  typedef logic [NPORTS-1:0][CW-1:0]    cnt_vec_t;

  port_vec_t         s1_q, s2_q;
  port_vec_t         cand_q, cand_d;
  port_vec_t         data_q, data_d;
  cnt_vec_t          cnt_q, cnt_d;
  logic [NPORTS-1:0] chg_q, chg_d;
  logic [NPORTS-1:0] commit;
  logic [NPORTS-1:0] status_clr;
  logic [NPORTS-1:0] mask_rd;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic [5:0]        rd_idx;
  logic              unused_bits;

  assign rd_idx      = addr[7:2];
  assign unused_bits = ^{addr[31:8], addr[1:0], wr_en, wr_data};

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  // Commit decision uses pre-edge cand/cnt, so a candidate that has just
  // reached the full count still commits even if s2 moves on this edge.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    commit = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (s2_q[k] != cand_q[k]) begin
        cand_d[k] = s2_q[k];
        cnt_d[k]  = '0;
      end else if (cnt_q[k] < CNT_MAX) begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
      if ((cnt_q[k] == CNT_MAX) && (cand_q[k] != data_q[k])) begin
        commit[k] = 1'b1;
        data_d[k] = cand_q[k];
      end
    end
  end

  assign status_clr = {NPORTS{rd_en && (rd_idx == IDX_STATUS)}} & chg_q;

  always_comb begin
    chg_d = (chg_q & ~status_clr) | commit;
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      cand_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      chg_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      chg_q  <= chg_d;
    end
  end

`ifdef IO_INPUT_IRQ_EN
  logic [NPORTS-1:0] mask_q, mask_d;
  logic              irq_q;

  always_comb begin
    mask_d = mask_q;
    if (wr_en && (rd_idx == IDX_MASK)) begin
      mask_d = wr_data[NPORTS-1:0];
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(chg_q & mask_q);
    end
  end

  assign mask_rd = mask_q;
  assign irq     = irq_q;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int k = 0; k < NPORTS; k++) begin
        if (rd_idx == 6'(k)) begin
          rd_data_d[WIDTH-1:0] = data_q[k];
        end
      end
      if (rd_idx == IDX_STATUS) begin
        rd_data_d[NPORTS-1:0] = chg_q;
      end
      if (rd_idx == IDX_MASK) begin
        rd_data_d[NPORTS-1:0] = mask_rd;
      end
    end
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign io_read_data = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule
